// File: rtl/rv_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pipe_pkg
// Description : Shared types and constants for the five-stage RV32I hazard and
//               control unit. Holds the forwarding-select encoding, the shadow
//               record of an in-flight instruction and the bubble constants.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pipe_pkg;

  // Widest register address in use (RV32I). RV32E builds zero-extend 4-bit
  // addresses into this width, which never changes a comparison result.
  localparam int unsigned RV_REG_ADDR_W_MAX = 5;

  typedef logic [RV_REG_ADDR_W_MAX-1:0] reg_addr_t;

  // EX-stage ALU operand source.
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  // Register-usage shadow of the instruction sitting in EX.
  typedef struct packed {
    reg_addr_t rd;
    logic      regwen;
    logic      memread;
    reg_addr_t rs1;
    reg_addr_t rs2;
  } stage_info_t;

  // MEM and WB only matter as producers, so they keep just the destination.
  typedef struct packed {
    reg_addr_t rd;
    logic      regwen;
  } dst_info_t;

  // Bubble: writes nothing, loads nothing, reads nothing.
  localparam stage_info_t C_STAGE_NOP = '{rd: '0, regwen: 1'b0, memread: 1'b0,
                                         rs1: '0, rs2: '0};
  localparam dst_info_t   C_DST_NOP   = '{rd: '0, regwen: 1'b0};

  // A producer stage supplies register src; x0 is never produced.
  function automatic logic writes_reg(dst_info_t s, reg_addr_t src);
    return s.regwen && (s.rd != '0) && (s.rd == src);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : rv_hazard_if
// Description : ID-stage register usage and pipeline status in, stall / flush
//               enables, forwarding selects and performance counters out.
//               The pipeline datapath is the master, the hazard unit the slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface rv_hazard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_regwen;
  logic                  id_memread;
  logic                  ex_redirect;
  logic                  mem_busy;

  logic                  pc_en;
  logic                  ifid_en;
  logic                  ifid_flush;
  logic                  idex_flush;
  logic                  pipe_en;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwen, id_memread, ex_redirect, mem_busy,
    input  pc_en, ifid_en, ifid_flush, idex_flush, pipe_en,
           fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwen, id_memread, ex_redirect, mem_busy,
    output pc_en, ifid_en, ifid_flush, idex_flush, pipe_en,
           fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );

endinterface
`default_nettype wire

// File: rtl/rv_hazard_unit_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
//               clear is synchronous and wins over inc.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 32
) (
  input  wire logic         clk,
  input  wire logic         inc,
  input  wire logic         clear,
  output logic [W-1:0]      count
);

  localparam logic [W-1:0] C_MAX = {W{1'b1}};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next value: increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != C_MAX)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/rv_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : rv_hazard_unit
// Description : Hazard and control unit for the five-stage RV32I pipeline.
//               Shadows the register usage of EX/MEM/WB, resolves load-use or
//               interlock stalls, redirect flushes and memory back-pressure,
//               drives EX operand forwarding and counts stalls and flushes.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_hazard_unit
  import rv_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 32
) (
  input  wire logic  clk,
  input  wire logic  reset,
  rv_hazard_if.slave bus
);

  stage_info_t ex_q, ex_d;
  dst_info_t   mem_q, mem_d;
  dst_info_t   wb_q, wb_d;

  stage_info_t w_id_info;
  dst_info_t   w_ex_dst;
  logic [2:0]  w_hit_rs1;   // [0]=EX, [1]=MEM, [2]=WB produce ID rs1
  logic [2:0]  w_hit_rs2;
  logic        w_hazard;
  fwd_sel_e    w_fwd_a;
  fwd_sel_e    w_fwd_b;

  logic        w_pc_en;
  logic        w_ifid_en;
  logic        w_ifid_flush;
  logic        w_idex_flush;
  logic        w_pipe_en;
  logic        w_stall_inc;
  logic        w_flush_inc;

  // Capture the ID instruction's usage; an invalid ID slot writes and loads nothing.
  always_comb begin
    w_id_info         = C_STAGE_NOP;
    w_id_info.rd      = reg_addr_t'(bus.id_rd);
    w_id_info.rs1     = reg_addr_t'(bus.id_rs1);
    w_id_info.rs2     = reg_addr_t'(bus.id_rs2);
    w_id_info.regwen  = bus.id_valid & bus.id_regwen;
    w_id_info.memread = bus.id_valid & bus.id_memread;
  end

  assign w_ex_dst = '{rd: ex_q.rd, regwen: ex_q.regwen};

  // Which older stages produce a register the ID instruction actually reads.
  always_comb begin
    w_hit_rs1[0] = bus.id_valid & bus.id_use_rs1 & writes_reg(w_ex_dst, w_id_info.rs1);
    w_hit_rs1[1] = bus.id_valid & bus.id_use_rs1 & writes_reg(mem_q,    w_id_info.rs1);
    w_hit_rs1[2] = bus.id_valid & bus.id_use_rs1 & writes_reg(wb_q,     w_id_info.rs1);
    w_hit_rs2[0] = bus.id_valid & bus.id_use_rs2 & writes_reg(w_ex_dst, w_id_info.rs2);
    w_hit_rs2[1] = bus.id_valid & bus.id_use_rs2 & writes_reg(mem_q,    w_id_info.rs2);
    w_hit_rs2[2] = bus.id_valid & bus.id_use_rs2 & writes_reg(wb_q,     w_id_info.rs2);
  end

  generate
    if (FWD_EN != 0) begin : g_fwd
      // Only a load still in EX cannot be forwarded in time.
      assign w_hazard = ex_q.memread & (w_hit_rs1[0] | w_hit_rs2[0]);
      // The younger producer (EX/MEM) holds the newer value, so it wins.
      assign w_fwd_a  = writes_reg(mem_q, ex_q.rs1) ? FWD_EXMEM :
                        writes_reg(wb_q,  ex_q.rs1) ? FWD_MEMWB : FWD_RF;
      assign w_fwd_b  = writes_reg(mem_q, ex_q.rs2) ? FWD_EXMEM :
                        writes_reg(wb_q,  ex_q.rs2) ? FWD_MEMWB : FWD_RF;
    end else begin : g_interlock
      // No bypass paths and no register-file write-through: wait until WB retires.
      assign w_hazard = |{w_hit_rs1, w_hit_rs2};
      assign w_fwd_a  = FWD_RF;
      assign w_fwd_b  = FWD_RF;
    end
  endgenerate

  // Pipeline control in priority order: back-pressure, redirect, hazard, run.
  always_comb begin
    w_pc_en      = 1'b1;
    w_ifid_en    = 1'b1;
    w_pipe_en    = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;
    if (bus.mem_busy) begin
      // Freeze everything; a held redirect is acted on once memory releases.
      w_pc_en   = 1'b0;
      w_ifid_en = 1'b0;
      w_pipe_en = 1'b0;
    end else if (bus.ex_redirect) begin
      // The ID instruction is on the wrong path, so its hazard is irrelevant.
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
      w_flush_inc  = 1'b1;
    end else if (w_hazard) begin
      w_pc_en      = 1'b0;
      w_ifid_en    = 1'b0;
      w_idex_flush = 1'b1;
      w_stall_inc  = 1'b1;
    end
  end

  // Shadow advance in lock-step with the datapath's ID/EX, EX/MEM, MEM/WB.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (w_pipe_en) begin
      wb_d  = mem_q;
      mem_d = w_ex_dst;
      ex_d  = w_idex_flush ? C_STAGE_NOP : w_id_info;
    end
  end

  // Shadow registers; reset empties the pipeline view even mid-stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= C_STAGE_NOP;
      mem_q <= C_DST_NOP;
      wb_q  <= C_DST_NOP;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .inc   (w_stall_inc),
    .clear (reset),
    .count (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .inc   (w_flush_inc),
    .clear (reset),
    .count (bus.flush_cnt)
  );

  assign bus.pc_en      = w_pc_en;
  assign bus.ifid_en    = w_ifid_en;
  assign bus.ifid_flush = w_ifid_flush;
  assign bus.idex_flush = w_idex_flush;
  assign bus.pipe_en    = w_pipe_en;
  assign bus.fwd_a_sel  = w_fwd_a;
  assign bus.fwd_b_sel  = w_fwd_b;

endmodule
`default_nettype wire

// File: tb/tb_rv_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_hazard_unit
// Description : Drives a forwarding build (32-bit counters) and an interlock
//               build (4-bit counters) with the same ID-stage stream. A model
//               of the instructions in flight predicts each cycle's outputs
//               into a queue; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_hazard_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rv_hazard_if #(.REG_ADDR_W(5), .CNT_W(32)) bus_f ();
  rv_hazard_if #(.REG_ADDR_W(5), .CNT_W(4))  bus_i ();

  rv_hazard_unit #(.REG_ADDR_W(5), .FWD_EN(1), .CNT_W(32)) dut_fwd (
    .clk (clk), .reset (reset), .bus (bus_f));
  rv_hazard_unit #(.REG_ADDR_W(5), .FWD_EN(0), .CNT_W(4)) dut_ilk (
    .clk (clk), .reset (reset), .bus (bus_i));

  typedef struct {
    bit reset, valid, u1, u2, wen, ld, redir, busy;
    int rs1, rs2, rd;
  } stim_t;

  // One instruction in flight: does it write rd, is it a load, what it reads.
  typedef struct {
    bit wr, ld;
    int rd, rs1, rs2;
  } instr_t;

  typedef struct {
    bit pc, ifid, ifl, idfl, pipe;
    int fa, fb;
    longint unsigned sc, fc;
  } exp_t;

  // flight[m][0]=EX, [1]=MEM, [2]=WB for model m (0 forwarding, 1 interlock)
  instr_t          flight[2][3];
  longint unsigned scnt[2], fcnt[2];
  exp_t            q_f[$], q_i[$];
  exp_t            mon_e;
  int              n_checks = 0;
  int              n_fail   = 0;

  function automatic bit produces(instr_t i, int r);
    return i.wr && (r != 0) && (i.rd == r);
  endfunction

  // Newest older instruction that produced r: 1 = one ahead (MEM), 2 = two ahead (WB).
  function automatic int fwd_code(int m, int r);
    if (m == 1) return 0;
    for (int k = 1; k < 3; k++) if (produces(flight[m][k], r)) return k;
    return 0;
  endfunction

  function automatic stim_t mk(bit v, bit u1, int r1, bit u2, int r2, bit w,
                               int rd, bit ld, bit rdr, bit bsy);
    stim_t s;
    s.reset = 0; s.valid = v; s.u1 = u1; s.rs1 = r1; s.u2 = u2; s.rs2 = r2;
    s.wen = w; s.rd = rd; s.ld = ld; s.redir = rdr; s.busy = bsy;
    return s;
  endfunction

  task automatic model_clear();
    instr_t empty;
    empty = '{wr: 0, ld: 0, rd: 0, rs1: 0, rs2: 0};
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 3; k++) flight[m][k] = empty;
      scnt[m] = 0;
      fcnt[m] = 0;
    end
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_out(string tag, exp_t e, logic pc, logic ifid, logic ifl,
                           logic idfl, logic pipe, logic [1:0] fa, logic [1:0] fb,
                           logic [63:0] sc, logic [63:0] fc);
    chk({tag, ".pc_en"},      64'(pc),   64'(e.pc));
    chk({tag, ".ifid_en"},    64'(ifid), 64'(e.ifid));
    chk({tag, ".ifid_flush"}, 64'(ifl),  64'(e.ifl));
    chk({tag, ".idex_flush"}, 64'(idfl), 64'(e.idfl));
    chk({tag, ".pipe_en"},    64'(pipe), 64'(e.pipe));
    chk({tag, ".fwd_a_sel"},  64'(fa),   64'(e.fa));
    chk({tag, ".fwd_b_sel"},  64'(fb),   64'(e.fb));
    chk({tag, ".stall_cnt"},  sc,        e.sc);
    chk({tag, ".flush_cnt"},  fc,        e.fc);
  endtask

  // Called #1 after a rising edge: drive one cycle, predict, advance the model.
  task automatic apply(stim_t s);
    exp_t            e;
    bit              haz, dep;
    longint unsigned cmax;
    instr_t          nxt;
    reset = s.reset;
    bus_f.id_valid = s.valid; bus_f.id_use_rs1 = s.u1; bus_f.id_use_rs2 = s.u2;
    bus_f.id_rs1 = 5'(s.rs1); bus_f.id_rs2 = 5'(s.rs2); bus_f.id_rd = 5'(s.rd);
    bus_f.id_regwen = s.wen; bus_f.id_memread = s.ld;
    bus_f.ex_redirect = s.redir; bus_f.mem_busy = s.busy;
    bus_i.id_valid = s.valid; bus_i.id_use_rs1 = s.u1; bus_i.id_use_rs2 = s.u2;
    bus_i.id_rs1 = 5'(s.rs1); bus_i.id_rs2 = 5'(s.rs2); bus_i.id_rd = 5'(s.rd);
    bus_i.id_regwen = s.wen; bus_i.id_memread = s.ld;
    bus_i.ex_redirect = s.redir; bus_i.mem_busy = s.busy;
    for (int m = 0; m < 2; m++) begin
      haz = 0;
      if (s.valid) begin
        for (int k = 0; k < 3; k++) begin
          dep = (s.u1 && produces(flight[m][k], s.rs1)) ||
                (s.u2 && produces(flight[m][k], s.rs2));
          if (m == 0) begin
            if (k == 0 && dep && flight[m][0].ld) haz = 1;
          end else if (dep) begin
            haz = 1;
          end
        end
      end
      e.pc = 1; e.ifid = 1; e.pipe = 1; e.ifl = 0; e.idfl = 0;
      if (s.busy) begin
        e.pc = 0; e.ifid = 0; e.pipe = 0;
      end else if (s.redir) begin
        e.ifl = 1; e.idfl = 1;
      end else if (haz) begin
        e.pc = 0; e.ifid = 0; e.idfl = 1;
      end
      e.fa = fwd_code(m, flight[m][0].rs1);
      e.fb = fwd_code(m, flight[m][0].rs2);
      e.sc = scnt[m];
      e.fc = fcnt[m];
      if (m == 0) q_f.push_back(e); else q_i.push_back(e);

      cmax = (m == 0) ? 64'hFFFF_FFFF : 64'd15;
      if (!s.reset && !s.busy) begin
        if (s.redir) begin
          if (fcnt[m] < cmax) fcnt[m]++;
        end else if (haz) begin
          if (scnt[m] < cmax) scnt[m]++;
        end
        nxt = '{wr: 0, ld: 0, rd: 0, rs1: 0, rs2: 0};
        if (!s.redir && !haz)
          nxt = '{wr: s.valid && s.wen, ld: s.valid && s.ld, rd: s.rd,
                  rs1: s.rs1, rs2: s.rs2};
        flight[m][2] = flight[m][1];
        flight[m][1] = flight[m][0];
        flight[m][0] = nxt;
      end
    end
    if (s.reset) model_clear();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each DUT against its predicted cycle, away from the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (q_f.size() > 0) begin
        mon_e = q_f.pop_front();
        check_out("fwd", mon_e, bus_f.pc_en, bus_f.ifid_en, bus_f.ifid_flush,
                  bus_f.idex_flush, bus_f.pipe_en, bus_f.fwd_a_sel, bus_f.fwd_b_sel,
                  64'(bus_f.stall_cnt), 64'(bus_f.flush_cnt));
      end
      if (q_i.size() > 0) begin
        mon_e = q_i.pop_front();
        check_out("ilk", mon_e, bus_i.pc_en, bus_i.ifid_en, bus_i.ifid_flush,
                  bus_i.idex_flush, bus_i.pipe_en, bus_i.fwd_a_sel, bus_i.fwd_b_sel,
                  64'(bus_i.stall_cnt), 64'(bus_i.flush_cnt));
      end
    end
  end

  stim_t dir[$];
  stim_t s;

  initial begin
    reset = 1'b1;
    bus_f.id_valid = 0; bus_f.id_use_rs1 = 0; bus_f.id_use_rs2 = 0;
    bus_f.id_rs1 = 0; bus_f.id_rs2 = 0; bus_f.id_rd = 0; bus_f.id_regwen = 0;
    bus_f.id_memread = 0; bus_f.ex_redirect = 0; bus_f.mem_busy = 0;
    bus_i.id_valid = 0; bus_i.id_use_rs1 = 0; bus_i.id_use_rs2 = 0;
    bus_i.id_rs1 = 0; bus_i.id_rs2 = 0; bus_i.id_rd = 0; bus_i.id_regwen = 0;
    bus_i.id_memread = 0; bus_i.ex_redirect = 0; bus_i.mem_busy = 0;
    @(posedge clk);
    #1;
    model_clear();

    //           v  u1 r1 u2 r2 w  rd ld rdr bsy
    dir.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // idle after reset
    dir.push_back(mk(1, 0, 0, 0, 0, 1, 5, 1, 0, 0));  // lw x5
    dir.push_back(mk(1, 1, 5, 0, 0, 1, 6, 0, 0, 0));  // use x5: load-use stall
    dir.push_back(mk(1, 1, 5, 0, 0, 1, 6, 0, 0, 0));  // retry proceeds
    dir.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // consumer in EX: fwd_a 10
    dir.push_back(mk(1, 1, 1, 0, 0, 1, 3, 0, 0, 0));  // add x3
    dir.push_back(mk(1, 0, 0, 1, 3, 1, 4, 0, 0, 0));  // sub ..,x3
    dir.push_back(mk(1, 1, 1, 0, 0, 1, 3, 0, 0, 0));  // add x3 (fwd_b 01 here)
    dir.push_back(mk(1, 0, 0, 0, 0, 1, 10, 0, 0, 0)); // independent
    dir.push_back(mk(1, 0, 0, 1, 3, 1, 4, 0, 0, 0));  // sub ..,x3
    dir.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // fwd_b 10
    dir.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0));  // lw x0
    dir.push_back(mk(1, 1, 0, 1, 0, 1, 2, 0, 0, 0));  // use x0: no stall
    dir.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0));  // write x7
    dir.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0));  // write x7 again
    dir.push_back(mk(1, 1, 7, 0, 0, 1, 8, 0, 0, 0));  // use x7
    dir.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // double match: 01
    dir.push_back(mk(1, 0, 0, 0, 0, 1, 5, 1, 0, 0));  // lw x5
    dir.push_back(mk(1, 1, 5, 0, 0, 1, 6, 0, 1, 0));  // use x5 with redirect
    dir.push_back(mk(1, 0, 0, 0, 0, 1, 9, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      dir.push_back(mk(1, 1, 9, 0, 0, 1, 2, 0, 1, 1)); // busy, redirect held
    dir.push_back(mk(1, 1, 9, 0, 0, 1, 2, 0, 1, 0));  // release: one flush
    dir.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // dependent chain into a reset mid-stall
    dir.push_back(mk(1, 1, 1, 0, 0, 1, 4, 0, 0, 0));
    dir.push_back(mk(1, 1, 4, 0, 0, 1, 5, 0, 0, 0));
    s = mk(1, 1, 4, 0, 0, 1, 5, 0, 0, 0); s.reset = 1;
    dir.push_back(s);
    dir.push_back(mk(1, 1, 4, 0, 0, 1, 5, 0, 0, 0));  // counters 0 after reset
    foreach (dir[i]) apply(dir[i]);

    // Saturation: 8 writer/consumer pairs, 3 interlock stalls each.
    s = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); s.reset = 1;
    apply(s);
    for (int i = 0; i < 8; i++) begin
      apply(mk(1, 1, 1, 0, 0, 1, 9, 0, 0, 0));
      for (int j = 0; j < 4; j++) apply(mk(1, 1, 9, 0, 0, 1, 11, 0, 0, 0));
    end
    @(negedge clk);
    chk("ilk.stall_cnt_saturated", 64'(bus_i.stall_cnt), 64'd15);
    chk("fwd.stall_cnt_no_stalls", 64'(bus_f.stall_cnt), 64'd0);
    @(posedge clk);
    #1;

    // Randomized traffic over a small register set to force collisions.
    for (int i = 0; i < 1500; i++) begin
      s.reset = ($urandom_range(0, 149) == 0);
      s.valid = ($urandom_range(0, 99) < 85);
      s.u1    = $urandom_range(0, 1);
      s.u2    = $urandom_range(0, 1);
      s.rs1   = $urandom_range(0, 7);
      s.rs2   = $urandom_range(0, 7);
      s.rd    = $urandom_range(0, 7);
      s.wen   = ($urandom_range(0, 99) < 75);
      s.ld    = ($urandom_range(0, 99) < 35);
      s.redir = ($urandom_range(0, 99) < 10);
      s.busy  = ($urandom_range(0, 99) < 15);
      apply(s);
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(q_f.size() + q_i.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
